// File: rtl/fifo_txuart.sv
// 8N1 UART transmitter that pulls bytes from a show-ahead FIFO, with CTS flow control
// and a line-break generator. Back-to-back frames are sent with no idle gap.
module fifo_txuart #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_fifo_empty_n,
    input  logic [7:0] i_fifo_data,
    output logic       o_fifo_rd,
    input  logic       i_cts_n,
    input  logic       i_break,
    output logic       o_uart_tx,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak,
        StMark
    } state_e;

    localparam logic [23:0] BaudReload = CLOCKS_PER_BAUD - 24'd1;

    // Declaration initialisers give the power-up state before the first reset.
    state_e      state_q = StIdle;
    state_e      state_d;
    logic [23:0] baud_cnt_q = 24'd0;
    logic [23:0] baud_cnt_d;
    logic [2:0]  bit_idx_q = 3'd0;
    logic [2:0]  bit_idx_d;
    logic [7:0]  shreg_q = 8'd0;
    logic [7:0]  shreg_d;
    logic        tx_q = 1'b1;
    logic        tx_d;
    logic        busy_q = 1'b0;
    logic        busy_d;

    logic        pop_ok;
    logic        pop;
    logic        baud_zero;
    logic [2:0]  bit_idx_inc;

    assign pop_ok      = i_fifo_empty_n && !i_cts_n && !i_break;
    assign baud_zero   = (baud_cnt_q == 24'd0);
    assign bit_idx_inc = bit_idx_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        pop        = 1'b0;

        case (state_q)
            StIdle: begin
                // Break wins over a pending pop.
                if (i_break) begin
                    state_d = StBreak;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else if (pop_ok) begin
                    pop        = 1'b1;
                    state_d    = StStart;
                    baud_cnt_d = BaudReload;
                    bit_idx_d  = 3'd0;
                    shreg_d    = i_fifo_data;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            StStart: begin
                if (baud_zero) begin
                    state_d    = StData;
                    baud_cnt_d = BaudReload;
                    bit_idx_d  = 3'd0;
                    tx_d       = shreg_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q - 24'd1;
                end
            end
            StData: begin
                if (baud_zero) begin
                    baud_cnt_d = BaudReload;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_inc;
                        tx_d      = shreg_q[bit_idx_inc];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 24'd1;
                end
            end
            StStop: begin
                if (baud_zero) begin
                    // Chain straight into the next start bit when another byte may go.
                    if (pop_ok) begin
                        pop        = 1'b1;
                        state_d    = StStart;
                        baud_cnt_d = BaudReload;
                        bit_idx_d  = 3'd0;
                        shreg_d    = i_fifo_data;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 24'd1;
                end
            end
            StBreak: begin
                if (!i_break) begin
                    state_d    = StMark;
                    baud_cnt_d = BaudReload;
                    tx_d       = 1'b1;
                end
            end
            StMark: begin
                if (baud_zero) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    baud_cnt_d = baud_cnt_q - 24'd1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            baud_cnt_q <= 24'd0;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign o_fifo_rd = pop && !i_rst;
    assign o_uart_tx = tx_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_fifo_txuart.sv
// Directed bench for fifo_txuart at 4 clocks per baud: a small FIFO model, a serial
// decoder scoreboard, per-cycle pop-strobe checks and hand-computed waveform checks.
module tb_fifo_txuart;

    localparam logic [23:0] Cpb = 24'd4;

    logic       i_clk;
    logic       i_rst;
    logic       i_fifo_empty_n;
    logic [7:0] i_fifo_data;
    logic       o_fifo_rd;
    logic       i_cts_n;
    logic       i_break;
    logic       o_uart_tx;
    logic       o_busy;

    fifo_txuart #(
        .CLOCKS_PER_BAUD(Cpb)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_fifo_empty_n(i_fifo_empty_n),
        .i_fifo_data   (i_fifo_data),
        .o_fifo_rd     (o_fifo_rd),
        .i_cts_n       (i_cts_n),
        .i_break       (i_break),
        .o_uart_tx     (o_uart_tx),
        .o_busy        (o_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Show-ahead FIFO model: head byte visible, popped on the strobe edge.
    logic [7:0]  fifo_mem [16];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    assign i_fifo_empty_n = (wr_ptr != rd_ptr);
    assign i_fifo_data    = fifo_mem[rd_ptr[3:0]];

    always @(posedge i_clk) begin
        if (o_fifo_rd) rd_ptr <= rd_ptr + 1;
    end

    int         n_checks = 0;
    int         n_fails = 0;
    int         cyc = 0;
    logic       s_tx;
    logic       s_busy;
    logic       s_rd;
    logic       prev_rd = 1'b0;
    bit         have_last = 1'b0;
    int         last_rd = 0;
    bit         mon_en = 1'b0;
    bit         dec_active = 1'b0;
    int         dec_cnt = 0;
    logic [7:0] dec_byte = 8'd0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] b, input bit expect_out);
        fifo_mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 1;
        if (expect_out) exp_q.push_back(b);
    endtask

    // Completes one clock cycle: samples at the falling edge, runs the pop-strobe
    // checks and the serial decoder, then returns just after the next rising edge.
    task automatic step();
        @(negedge i_clk);
        cyc++;
        s_tx   = o_uart_tx;
        s_busy = o_busy;
        s_rd   = o_fifo_rd;
        if (i_rst) have_last = 1'b0;
        if (o_fifo_rd) begin
            check("rd_when_empty", 32'(i_fifo_empty_n), 32'd1);
            check("rd_back_to_back", 32'(prev_rd), 32'd0);
            if (have_last) check("rd_spacing_ge_40", 32'((cyc - last_rd) >= 40), 32'd1);
            have_last = 1'b1;
            last_rd   = cyc;
        end
        prev_rd = o_fifo_rd;

        if (!mon_en || i_rst) begin
            dec_active = 1'b0;
        end else if (!dec_active) begin
            if (!o_uart_tx) begin
                dec_active = 1'b1;
                dec_cnt    = 0;
            end
        end else begin
            dec_cnt++;
            if (dec_cnt == 2) check("start_bit", 32'(o_uart_tx), 32'd0);
            if (dec_cnt >= 6 && dec_cnt <= 34 && (dec_cnt % 4) == 2)
                dec_byte[3'((dec_cnt - 6) / 4)] = o_uart_tx;
            if (dec_cnt == 38) begin
                check("stop_bit", 32'(o_uart_tx), 32'd1);
                if (exp_q.size() == 0) check("sb_unexpected_byte", 32'(exp_q.size()), 32'd1);
                else check("sb_byte", 32'(dec_byte), 32'(exp_q.pop_front()));
                dec_active = 1'b0;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int         np;
    int         pulses [4];
    logic       tx_log [130];
    int         busy_cnt;
    int         rd_cnt;
    int         low_cnt;
    logic [7:0] a5;
    logic       exp_tx;

    initial begin
        i_rst   = 1'b1;
        i_cts_n = 1'b0;
        i_break = 1'b0;
        mon_en  = 1'b0;

        // Reset with a byte waiting: strobe must stay low until release.
        push(8'h11, 1'b1);
        step();
        check("rst_rd_gated", 32'(s_rd), 32'd0);
        step();
        step();
        check("rst_tx", 32'(s_tx), 32'd1);
        check("rst_busy", 32'(s_busy), 32'd0);
        check("rst_rd", 32'(s_rd), 32'd0);
        i_rst  = 1'b0;
        mon_en = 1'b1;
        step();
        check("post_rst_pop", 32'(s_rd), 32'd1);
        idle_steps(45);

        // Single frame of 8'hA5, cycle-exact waveform.
        a5 = 8'hA5;
        push(a5, 1'b1);
        step();
        check("a5_pop", 32'(s_rd), 32'd1);
        for (int k = 1; k <= 41; k++) begin
            step();
            if (k <= 4) exp_tx = 1'b0;
            else if (k <= 36) exp_tx = a5[3'((k - 5) / 4)];
            else exp_tx = 1'b1;
            check("a5_tx", 32'(s_tx), 32'(exp_tx));
            check("a5_busy", 32'(s_busy), 32'(k <= 40));
            check("a5_no_pop", 32'(s_rd), 32'd0);
        end

        // Three queued bytes go out back to back.
        push(8'h3C, 1'b1);
        push(8'h81, 1'b1);
        push(8'h7E, 1'b1);
        np       = 0;
        busy_cnt = 0;
        for (int i = 0; i < 130; i++) begin
            step();
            tx_log[i] = s_tx;
            if (s_busy) busy_cnt++;
            if (s_rd && np < 4) begin
                pulses[np] = i;
                np++;
            end
        end
        check("b2b_pulse_count", 32'(np), 32'd3);
        if (np == 3 && pulses[2] < 129) begin
            check("b2b_gap1", 32'(pulses[1] - pulses[0]), 32'd40);
            check("b2b_gap2", 32'(pulses[2] - pulses[1]), 32'd40);
            check("b2b_start1_low", 32'(tx_log[pulses[1] + 1]), 32'd0);
            check("b2b_start2_low", 32'(tx_log[pulses[2] + 1]), 32'd0);
        end
        check("b2b_busy_cycles", 32'(busy_cnt), 32'd120);
        check("b2b_idle_after", 32'(s_busy), 32'd0);

        // CTS holds off the first frame, then withholds the next one mid-frame.
        i_cts_n = 1'b1;
        push(8'h55, 1'b1);
        rd_cnt  = 0;
        low_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_rd) rd_cnt++;
            if (!s_tx) low_cnt++;
        end
        check("cts_no_pop", 32'(rd_cnt), 32'd0);
        check("cts_tx_idle", 32'(low_cnt), 32'd0);
        i_cts_n = 1'b0;
        step();
        check("cts_release_pop", 32'(s_rd), 32'd1);
        idle_steps(10);
        i_cts_n = 1'b1;
        push(8'h66, 1'b1);
        rd_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (s_rd) rd_cnt++;
        end
        check("cts_midframe_no_pop", 32'(rd_cnt), 32'd0);
        check("cts_midframe_idle", 32'(s_busy), 32'd0);
        check("cts_midframe_tx", 32'(s_tx), 32'd1);
        i_cts_n = 1'b0;
        step();
        check("cts_second_pop", 32'(s_rd), 32'd1);
        idle_steps(45);

        // Ten-cycle break with a byte waiting, then a one-baud mark.
        mon_en  = 1'b0;
        i_break = 1'b1;
        push(8'hBB, 1'b1);
        step();
        check("brk_no_pop0", 32'(s_rd), 32'd0);
        for (int i = 1; i <= 9; i++) begin
            step();
            check("brk_tx_low", 32'(s_tx), 32'd0);
            check("brk_no_pop", 32'(s_rd), 32'd0);
        end
        i_break = 1'b0;
        step();
        check("brk_tx_low_last", 32'(s_tx), 32'd0);
        check("brk_busy", 32'(s_busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("mark_tx_high", 32'(s_tx), 32'd1);
            check("mark_busy", 32'(s_busy), 32'd1);
            check("mark_no_pop", 32'(s_rd), 32'd0);
        end
        mon_en = 1'b1;
        step();
        check("brk_then_idle", 32'(s_busy), 32'd0);
        check("brk_then_pop", 32'(s_rd), 32'd1);
        idle_steps(45);

        // Reset during data bit 3 aborts the frame; next byte pops after release.
        mon_en = 1'b0;
        push(8'hC3, 1'b0);
        push(8'h5A, 1'b1);
        step();
        check("abort_pop", 32'(s_rd), 32'd1);
        idle_steps(17);
        check("abort_in_bit3", 32'(s_tx), 32'd0);
        i_rst = 1'b1;
        step();
        check("abort_rst_no_pop0", 32'(s_rd), 32'd0);
        step();
        check("abort_tx_high", 32'(s_tx), 32'd1);
        check("abort_busy_low", 32'(s_busy), 32'd0);
        check("abort_rst_no_pop1", 32'(s_rd), 32'd0);
        i_rst  = 1'b0;
        mon_en = 1'b1;
        step();
        check("abort_release_pop", 32'(s_rd), 32'd1);
        check("abort_release_tx", 32'(s_tx), 32'd1);
        idle_steps(45);

        check("sb_all_bytes_seen", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
